// File: rtl/io_device_port_pkg.sv
// io_device_port_pkg: shared definitions for the device-side byte I/O port.
//   - Default data width and FIFO depth.
//   - State encodings for the feed FSM (device -> processor).
//   - State encodings for the capture FSM (processor -> device).
package io_device_port_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_FIFO_ADDR_BITS = 2;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_PRESENT = 2'd1,
    F_RELEASE = 2'd2
  } feed_state_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_ACK  = 1'b1
  } cap_state_t;

endpackage

// File: rtl/io_device_port_byte_fifo.sv
// byte_fifo: circular FIFO of 2**FifoAddrBits entries.
//   push/din  - write din when not full (push while full is dropped)
//   pop       - drop the head when not empty (pop while empty is ignored)
//   dout      - head entry, or 0 while empty
//   full/empty/count - occupancy derived from registered count only
module byte_fifo #(
  parameter int DataWidth    = 8,
  parameter int FifoAddrBits = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [DataWidth-1:0]    din,
  input  logic                    pop,
  output logic [DataWidth-1:0]    dout,
  output logic                    full,
  output logic                    empty,
  output logic [FifoAddrBits:0]   count
);

  localparam int Depth = 1 << FifoAddrBits;

  logic [DataWidth-1:0]    mem [Depth];
  logic [FifoAddrBits-1:0] wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  // count never exceeds Depth, so its MSB alone marks full
  assign full    = count[FifoAddrBits];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_device_port.sv
// io_device_port: device end of the processor's 4-phase byte handshakes.
//   Feed path   : src_* stream -> feed FIFO -> cpu_in / cpu_inDataReady / cpu_inACK
//   Capture path: cpu_out / cpu_outDataReady / cpu_outACK -> capture FIFO -> sink_*
//   feed_count / cap_count report FIFO occupancy.
// Both paths run independently and may handshake in the same cycle.
module io_device_port
  import io_device_port_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_WIDTH,
  parameter int FifoAddrBits = DEF_FIFO_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DataWidth-1:0]  src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [DataWidth-1:0]  sink_data,
  output logic                  sink_valid,
  input  logic                  sink_ready,
  output logic [DataWidth-1:0]  cpu_in,
  output logic                  cpu_inDataReady,
  input  logic                  cpu_inACK,
  input  logic [DataWidth-1:0]  cpu_out,
  input  logic                  cpu_outDataReady,
  output logic                  cpu_outACK,
  output logic [FifoAddrBits:0] feed_count,
  output logic [FifoAddrBits:0] cap_count
);

  feed_state_t          fstate;
  cap_state_t           cstate;
  logic [DataWidth-1:0] feed_head;
  logic                 feed_full, feed_empty, feed_push, feed_pop;
  logic                 cap_full, cap_empty, cap_push, cap_pop;

  // ---------------- feed path ----------------
  assign src_ready = !feed_full;
  assign feed_push = src_valid && src_ready;
  assign feed_pop  = (fstate == F_IDLE) && !feed_empty;

  byte_fifo #(.DataWidth(DataWidth), .FifoAddrBits(FifoAddrBits)) u_feed_fifo (
    .clk(clk), .reset(reset),
    .push(feed_push), .din(src_data),
    .pop(feed_pop), .dout(feed_head),
    .full(feed_full), .empty(feed_empty), .count(feed_count)
  );

  // cpu_inDataReady is an interrupt level on the processor side, so it is
  // held until acked and never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fstate          <= F_IDLE;
      cpu_in          <= '0;
      cpu_inDataReady <= 1'b0;
    end else begin
      case (fstate)
        F_IDLE: if (!feed_empty) begin
          cpu_in          <= feed_head;
          cpu_inDataReady <= 1'b1;
          fstate          <= F_PRESENT;
        end
        F_PRESENT: if (cpu_inACK) begin
          cpu_inDataReady <= 1'b0;
          fstate          <= F_RELEASE;
        end
        F_RELEASE: if (!cpu_inACK) fstate <= F_IDLE;
        default: fstate <= F_IDLE;
      endcase
    end
  end

  // ---------------- capture path ----------------
  assign sink_valid = !cap_empty;
  assign cap_pop    = sink_valid && sink_ready;
  // Only C_IDLE pushes, so a long outDataReady yields a single entry.
  assign cap_push   = (cstate == C_IDLE) && cpu_outDataReady && !cap_full;

  byte_fifo #(.DataWidth(DataWidth), .FifoAddrBits(FifoAddrBits)) u_cap_fifo (
    .clk(clk), .reset(reset),
    .push(cap_push), .din(cpu_out),
    .pop(cap_pop), .dout(sink_data),
    .full(cap_full), .empty(cap_empty), .count(cap_count)
  );

  // A full capture FIFO withholds the ACK, stalling the processor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cstate     <= C_IDLE;
      cpu_outACK <= 1'b0;
    end else begin
      case (cstate)
        C_IDLE: if (cap_push) begin
          cpu_outACK <= 1'b1;
          cstate     <= C_ACK;
        end
        C_ACK: if (!cpu_outDataReady) begin
          cpu_outACK <= 1'b0;
          cstate     <= C_IDLE;
        end
        default: cstate <= C_IDLE;
      endcase
    end
  end

endmodule
